instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   localparam int PC_STEP = 4;
   localparam int INSTR_W = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, instr}, head visible combinationally,
// flush clears all entries in one cycle.
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int WIDTH = INSTR_W + 32,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && (count_q != CNT_W'(DEPTH));

   // Pointers are PTR_W bits wide and wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: PC, single-outstanding memory read, prefetch
// FIFO with valid/ready output and flushing PC redirect.
module instr_fetch import fetch_pkg::*; #(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_rvalid,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc
);

   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = INSTR_W + ADDR_W;

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               mem_req_q, mem_req_d;
   logic               push, pop, can_issue;
   logic [ADDR_W-1:0]  redirect_aligned;
   logic [ENTRY_W-1:0] head;
   logic [CNT_W-1:0]   count;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata ({mem_addr_q, mem_rdata}),
      .head  (head),
      .count (count)
   );

   assign instr_valid      = (count != '0);
   assign instr            = instr_valid ? head[INSTR_W-1:0] : '0;
   assign instr_pc         = instr_valid ? head[ENTRY_W-1:INSTR_W] : '0;
   assign pop              = instr_valid && instr_ready && !redirect;
   assign can_issue        = (count < CNT_W'(DEPTH));
   assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

   // mem_addr_q keeps the address of the outstanding request, so it doubles
   // as the PC tag pushed alongside the returned word.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_req_d  = 1'b0;
      mem_addr_d = mem_addr_q;
      push       = 1'b0;
      case (state_q)
         FETCH: begin
            if (!redirect && can_issue) begin
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               push    = !redirect;
               state_d = FETCH;
            end else if (redirect) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (mem_rvalid) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
      if (redirect) fetch_pc_d = redirect_aligned;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: latency-1 streaming, full FIFO back-pressure,
// redirects, PC wrap-around and mid-operation reset.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req, mem_rvalid, instr_valid, instr_ready, redirect;
   logic [31:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;

   logic        mem_req1, mem_rvalid1, instr_valid1;
   logic [31:0] mem_addr1, mem_rdata1, instr1, instr_pc1;

   int          ncmp = 0;
   int          nfail = 0;
   int          lat = 1;
   int          cnt = 0;
   bit          mem_auto = 1'b1;
   logic [31:0] pend_addr;

   int          nreq, nreq1, got;
   logic [31:0] last_addr, first_addr, first_pc, first_instr;
   logic [31:0] wrap_addr [3];

   always #5 clk = ~clk;

   instr_fetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr(instr),
      .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   instr_fetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req1), .mem_addr(mem_addr1),
      .mem_rvalid(mem_rvalid1), .mem_rdata(mem_rdata1), .instr(instr1),
      .instr_pc(instr_pc1), .instr_valid(instr_valid1), .instr_ready(1'b1),
      .redirect(1'b0), .redirect_pc(32'h0)
   );

   // Memory model: rvalid is sampled lat rising edges after the request edge.
   always @(negedge clk) begin
      if (mem_auto) begin
         mem_rvalid = 1'b0;
         if (!rst_n) cnt = 0;
         if (mem_req) begin
            pend_addr = mem_addr;
            cnt = lat;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = pend_addr ^ 32'hA5A5_0000;
            end
         end
      end
   end

   always @(negedge clk) begin
      mem_rvalid1 = mem_req1;
      mem_rdata1  = mem_addr1 ^ 32'hA5A5_0000;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect = 1'b0;
      mem_rvalid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
      instr_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

      // Reset values
      repeat (2) tick();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      rst_n = 1'b1;

      // Latency-1 streaming with ready = 1
      tick();
      check("t1_req0", mem_req, 1);
      check("t1_addr0", mem_addr, 32'h0);
      tick();
      check("t1_valid0", instr_valid, 1);
      check("t1_pc0", instr_pc, 32'h0);
      check("t1_instr0", instr, 32'hA5A5_0000);
      check("t1_req_gap", mem_req, 0);
      tick();
      check("t1_req1", mem_req, 1);
      check("t1_addr1", mem_addr, 32'h4);
      check("t1_popped", instr_valid, 0);
      tick();
      check("t1_pc1", instr_pc, 32'h4);
      check("t1_instr1", instr, 32'hA5A5_0004);
      $display("txn t1 streaming done");

      // Back-pressure fills the FIFO; dut1 checks PC wrap meanwhile
      instr_ready = 1'b0; lat = 1; mem_auto = 1'b1;
      do_reset();
      nreq = 0; nreq1 = 0; last_addr = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mem_req) begin nreq++; last_addr = mem_addr; end
         if (mem_req1 && nreq1 < 3) begin wrap_addr[nreq1] = mem_addr1; nreq1++; end
         if (i == 1) begin
            check("t5_valid", instr_valid1, 1);
            check("t5_pc", instr_pc1, 32'hFFFF_FFF8);
            check("t5_instr", instr1, 32'h5A5A_FFF8);
         end
      end
      check("t2_nreq", nreq, 4);
      check("t2_last_addr", last_addr, 32'hC);
      check("t2_valid_held", instr_valid, 1);
      check("t2_head_pc", instr_pc, 32'h0);
      check("t2_no_req", mem_req, 0);
      check("t5_nreq", nreq1, 3);
      check("t5_wrap0", wrap_addr[0], 32'hFFFF_FFF8);
      check("t5_wrap1", wrap_addr[1], 32'hFFFF_FFFC);
      check("t5_wrap2", wrap_addr[2], 32'h0000_0000);
      instr_ready = 1'b1;
      got = 0; first_addr = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         check("t2_drain_valid", instr_valid, 1);
         check("t2_drain_pc", instr_pc, i * 4);
         check("t2_drain_instr", instr, (i * 4) ^ 32'hA5A5_0000);
         tick();
         if (mem_req && got == 0) begin got = 1; first_addr = mem_addr; end
      end
      check("t2_resume_addr", first_addr, 32'h10);
      check("t2_next_pc", instr_pc, 32'h10);
      $display("txn t2 backpressure/drain done, t5 wrap done");

      // Redirect while waiting on a latency-3 response
      lat = 3;
      do_reset();
      tick();
      check("t3_req0", mem_req, 1);
      redirect = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect = 1'b0;
      check("t3_no_req_redirect", mem_req, 0);
      got = 0; first_addr = 32'hFFFF_FFFF; first_pc = 32'hFFFF_FFFF; first_instr = '0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (mem_req && first_addr == 32'hFFFF_FFFF) first_addr = mem_addr;
         if (instr_valid) begin got = 1; first_pc = instr_pc; first_instr = instr; break; end
      end
      check("t3_seen_valid", got, 1);
      check("t3_first_addr", first_addr, 32'h100);
      check("t3_first_pc", first_pc, 32'h100);
      check("t3_first_instr", first_instr, 32'hA5A5_0100);
      $display("txn t3 redirect-in-wait done");

      // Redirect coincident with rvalid and a pop
      lat = 1; mem_auto = 1'b0; instr_ready = 1'b0;
      do_reset();
      tick();
      check("t4_req0", mem_req, 1);
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      tick();
      mem_rvalid = 1'b0;
      tick();
      check("t4_req1", mem_req, 1);
      check("t4_addr1", mem_addr, 32'h4);
      check("t4_pre_valid", instr_valid, 1);
      mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
      redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
      tick();
      mem_rvalid = 1'b0; redirect = 1'b0;
      check("t4_flushed", instr_valid, 0);
      check("t4_instr_zero", instr, 32'h0);
      check("t4_pc_zero", instr_pc, 32'h0);
      check("t4_no_req", mem_req, 0);
      tick();
      check("t4_req_redir", mem_req, 1);
      check("t4_addr_redir", mem_addr, 32'h200);
      mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
      tick();
      mem_rvalid = 1'b0;
      check("t4_valid", instr_valid, 1);
      check("t4_pc", instr_pc, 32'h200);
      check("t4_instr", instr, 32'h3333_3333);
      $display("txn t4 redirect-with-rvalid done");

      // Reset in WAIT with two words buffered
      instr_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         tick();
         mem_rvalid = 1'b1; mem_rdata = 32'h5000_0000 + i;
         tick();
         mem_rvalid = 1'b0;
      end
      tick();
      check("t6_req_wait", mem_req, 1);
      check("t6_addr_wait", mem_addr, 32'h8);
      check("t6_pre_pc", instr_pc, 32'h0);
      rst_n = 1'b0;
      tick();
      check("t6_rst_req", mem_req, 0);
      check("t6_rst_addr", mem_addr, 32'h0);
      check("t6_rst_valid", instr_valid, 0);
      check("t6_rst_instr", instr, 32'h0);
      check("t6_rst_pc", instr_pc, 32'h0);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_rvalid = 1'b0;
      check("t6_stray_ignored", instr_valid, 0);
      check("t6_restart_req", mem_req, 1);
      check("t6_restart_addr", mem_addr, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
      tick();
      mem_rvalid = 1'b0;
      check("t6_valid", instr_valid, 1);
      check("t6_pc", instr_pc, 32'h0);
      check("t6_instr", instr, 32'h4444_4444);
      $display("txn t6 mid-operation reset done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
